// File: rtl/lsu_align.sv
// Load/store alignment unit: steers store lanes, builds byte enables, extends load
// data and splits line-straddling accesses into two memory cycles.
module lsu_align #(
   parameter int MISALIGN_EN = 1,
   parameter int DMEM_AW     = 14
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] daddr,
   output logic [31:0] dwdata,
   output logic [3:0]  dwe,
   input  logic [31:0] drdata
);

   typedef enum logic {IDLE, SECOND} state_t;

   state_t      state;
   logic [31:0] hold_addr;
   logic [31:0] hold_wdata;
   logic [31:0] hold_rdata;
   logic [2:0]  hold_funct3;
   logic        hold_we;

   logic        in_second;
   logic        accept;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [2:0]  cur_funct3;
   logic        cur_we;
   logic [1:0]  off;
   logic [7:0]  base;
   logic [7:0]  mask8;
   logic        misaligned;
   logic        size_ok;
   logic        range_ok;
   logic        last_line;
   logic        err;
   logic [5:0]  sh_lo;
   logic [5:0]  sh_hi;
   logic [63:0] pair;
   logic [31:0] raw;
   logic [31:0] ext;

   function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] v);
      case (f)
         3'b000:  extend = {{24{v[7]}}, v[7:0]};
         3'b001:  extend = {{16{v[15]}}, v[15:0]};
         3'b100:  extend = {24'h0, v[7:0]};
         3'b101:  extend = {16'h0, v[15:0]};
         default: extend = v;
      endcase
   endfunction

   assign req_ready = (state == IDLE) & ~reset;
   assign accept    = req_valid & req_ready;

   // In SECOND the held request drives the same decode path as a live one.
   always_comb begin
      in_second  = (state == SECOND);
      cur_addr   = in_second ? hold_addr   : req_addr;
      cur_wdata  = in_second ? hold_wdata  : req_wdata;
      cur_funct3 = in_second ? hold_funct3 : req_funct3;
      cur_we     = in_second ? hold_we     : req_we;
      off        = cur_addr[1:0];
      case (cur_funct3[1:0])
         2'b00:   base = 8'h01;
         2'b01:   base = 8'h03;
         default: base = 8'h0F;
      endcase
      mask8      = base << off;
      misaligned = |mask8[7:4];
      size_ok    = (cur_funct3 == 3'b000) || (cur_funct3 == 3'b001) || (cur_funct3 == 3'b010) ||
                   (cur_funct3 == 3'b100) || (cur_funct3 == 3'b101);
      range_ok   = ((cur_addr >> DMEM_AW) == 32'h0);
      last_line  = &cur_addr[DMEM_AW-1:2];
      err        = !size_ok || !range_ok || (misaligned && ((MISALIGN_EN == 0) || last_line));
      sh_lo      = {1'b0, off, 3'b000};
      sh_hi      = {3'd4 - {1'b0, off}, 3'b000};
      pair       = in_second ? {drdata, hold_rdata} : {32'h0, drdata};
      raw        = 32'(pair >> sh_lo);
      ext        = extend(cur_funct3, raw);
      daddr      = in_second ? {cur_addr[31:2] + 30'd1, 2'b00} : {cur_addr[31:2], 2'b00};
      dwdata     = in_second ? (cur_wdata >> sh_hi) : (cur_wdata << sh_lo);
      dwe        = '0;
      if (!reset && cur_we) begin
         if (in_second)
            dwe = mask8[7:4];
         else if (accept && !err)
            dwe = mask8[3:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         resp_valid  <= 1'b0;
         resp_err    <= 1'b0;
         resp_rdata  <= '0;
         hold_addr   <= '0;
         hold_wdata  <= '0;
         hold_rdata  <= '0;
         hold_funct3 <= '0;
         hold_we     <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (err) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (misaligned) begin
                     state       <= SECOND;
                     hold_addr   <= req_addr;
                     hold_wdata  <= req_wdata;
                     hold_funct3 <= req_funct3;
                     hold_we     <= req_we;
                     hold_rdata  <= drdata;
                  end else begin
                     resp_valid <= 1'b1;
                     resp_rdata <= req_we ? '0 : ext;
                  end
               end
            end
            SECOND: begin
               state      <= IDLE;
               resp_valid <= 1'b1;
               resp_rdata <= hold_we ? '0 : ext;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: a byte-lane memory model behind the main instance,
// plus a second instance built with misaligned splitting disabled.
module tb_lsu_align;

   logic        clk;
   logic        reset;
   logic        mem_init;

   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata, daddr, dwdata, drdata;
   logic [3:0]  dwe;

   logic        n_req_valid, n_req_ready, n_req_we;
   logic [2:0]  n_req_funct3;
   logic [31:0] n_req_addr, n_req_wdata;
   logic        n_resp_valid, n_resp_err;
   logic [31:0] n_resp_rdata, n_daddr, n_dwdata, n_drdata;
   logic [3:0]  n_dwe;

   lsu_align #(.MISALIGN_EN(1), .DMEM_AW(14)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
   );

   lsu_align #(.MISALIGN_EN(0), .DMEM_AW(14)) u_dut0 (
      .clk(clk), .reset(reset),
      .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
      .req_funct3(n_req_funct3), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
      .resp_valid(n_resp_valid), .resp_err(n_resp_err), .resp_rdata(n_resp_rdata),
      .daddr(n_daddr), .dwdata(n_dwdata), .dwe(n_dwe), .drdata(n_drdata)
   );

   assign n_drdata = 32'h11223344;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [0:4095];
   int          wr_cnt;

   assign drdata = mem[daddr[13:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         mem[0]    <= 32'h44332211;
         mem[1]    <= 32'h88776655;
         mem[2]    <= 32'h00000000;
         mem[4095] <= 32'hCAFEF00D;
         wr_cnt    <= 0;
      end else if (dwe != 4'b0000) begin
         wr_cnt <= wr_cnt + 1;
         for (int i = 0; i < 4; i++)
            if (dwe[i]) mem[daddr[13:2]][8*i +: 8] <= dwdata[8*i +: 8];
      end
   end

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp, input logic exp_err, input int exp_lat);
      vec_t v;
      v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.exp = exp; v.exp_err = exp_err; v.exp_lat = exp_lat;
      return v;
   endfunction

   int vec_cnt = 0;
   int miss    = 0;

   logic [31:0] c1_daddr, c1_dwdata, c2_daddr, c2_dwdata;
   logic [3:0]  c1_dwe, c2_dwe;
   logic        c2_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drives one request, captures the accept cycle (c1) and the cycle after (c2),
   // then waits (bounded) for the response and checks it.
   task automatic issue(input vec_t v);
      int lat;
      int w0;
      @(negedge clk);
      req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
      w0 = wr_cnt;
      #1;
      check({v.name, " ready"}, 32'(req_ready), 32'd1);
      c1_daddr = daddr; c1_dwe = dwe; c1_dwdata = dwdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      #1;
      c2_daddr = daddr; c2_dwe = dwe; c2_dwdata = dwdata; c2_ready = req_ready;
      lat = 1;
      while (!resp_valid && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
      check({v.name, " rdata"}, resp_rdata, v.exp);
      check({v.name, " err"}, 32'(resp_err), 32'(v.exp_err));
      if (v.exp_err) check({v.name, " writes"}, 32'(wr_cnt - w0), 32'd0);
   endtask

   vec_t loads [11];
   vec_t errs  [4];

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      loads[0]  = mk("LB 0x7",     1'b0, 3'b000, 32'h7,    32'h0, 32'hFFFFFF88, 1'b0, 1);
      loads[1]  = mk("LBU 0x7",    1'b0, 3'b100, 32'h7,    32'h0, 32'h00000088, 1'b0, 1);
      loads[2]  = mk("LH 0x2",     1'b0, 3'b001, 32'h2,    32'h0, 32'h00004433, 1'b0, 1);
      loads[3]  = mk("LH 0x6",     1'b0, 3'b001, 32'h6,    32'h0, 32'hFFFF8877, 1'b0, 1);
      loads[4]  = mk("LHU 0x6",    1'b0, 3'b101, 32'h6,    32'h0, 32'h00008877, 1'b0, 1);
      loads[5]  = mk("LW 0x4",     1'b0, 3'b010, 32'h4,    32'h0, 32'h88776655, 1'b0, 1);
      loads[6]  = mk("LW 0x1",     1'b0, 3'b010, 32'h1,    32'h0, 32'h55443322, 1'b0, 2);
      loads[7]  = mk("LH 0x3",     1'b0, 3'b001, 32'h3,    32'h0, 32'h00005544, 1'b0, 2);
      loads[8]  = mk("LHU 0x7",    1'b0, 3'b101, 32'h7,    32'h0, 32'h00000088, 1'b0, 2);
      loads[9]  = mk("LW 0x3FFC",  1'b0, 3'b010, 32'h3FFC, 32'h0, 32'hCAFEF00D, 1'b0, 1);
      loads[10] = mk("LB 0x3FFF",  1'b0, 3'b000, 32'h3FFF, 32'h0, 32'hFFFFFFCA, 1'b0, 1);
      errs[0]   = mk("SW 0x4000",  1'b1, 3'b010, 32'h4000, 32'h11111111, 32'h0, 1'b1, 1);
      errs[1]   = mk("SW 0x3FFF",  1'b1, 3'b010, 32'h3FFF, 32'h22222222, 32'h0, 1'b1, 1);
      errs[2]   = mk("S f3=011",   1'b1, 3'b011, 32'h8,    32'h33333333, 32'h0, 1'b1, 1);
      errs[3]   = mk("L f3=110",   1'b0, 3'b110, 32'h0,    32'h0,        32'h0, 1'b1, 1);

      reset = 1'b1; mem_init = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hFFFFFFFF;
      n_req_valid = 1'b1; n_req_we = 1'b1; n_req_funct3 = 3'b010; n_req_addr = 32'h0; n_req_wdata = 32'h0;
      repeat (2) @(negedge clk);
      check("reset req_ready", 32'(req_ready), 32'd0);
      check("reset dwe", 32'(dwe), 32'd0);
      check("reset resp_valid", 32'(resp_valid), 32'd0);
      check("reset resp_err", 32'(resp_err), 32'd0);
      check("reset resp_rdata", resp_rdata, 32'h0);
      mem_init = 1'b0; req_valid = 1'b0; n_req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post-reset req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 11; i++) issue(loads[i]);

      issue(mk("LW 0x1 split", 1'b0, 3'b010, 32'h1, 32'h0, 32'h55443322, 1'b0, 2));
      check("LW 0x1 c1 daddr", c1_daddr, 32'h0);
      check("LW 0x1 c1 dwe", 32'(c1_dwe), 32'd0);
      check("LW 0x1 c2 daddr", c2_daddr, 32'h4);
      check("LW 0x1 c2 ready", 32'(c2_ready), 32'd0);

      issue(mk("SH 0x2", 1'b1, 3'b001, 32'h2, 32'h0000A5B6, 32'h0, 1'b0, 1));
      check("SH 0x2 daddr", c1_daddr, 32'h0);
      check("SH 0x2 dwe", 32'(c1_dwe), 32'b1100);
      check("SH 0x2 dwdata", c1_dwdata, 32'hA5B60000);
      check("SH 0x2 no 2nd write", 32'(c2_dwe), 32'd0);
      issue(mk("LW 0x0 after SH", 1'b0, 3'b010, 32'h0, 32'h0, 32'hA5B62211, 1'b0, 1));

      issue(mk("SW 0x3", 1'b1, 3'b010, 32'h3, 32'hDEADBEEF, 32'h0, 1'b0, 2));
      check("SW 0x3 c1 daddr", c1_daddr, 32'h0);
      check("SW 0x3 c1 dwe", 32'(c1_dwe), 32'b1000);
      check("SW 0x3 c1 dwdata", c1_dwdata, 32'hEF000000);
      check("SW 0x3 c2 daddr", c2_daddr, 32'h4);
      check("SW 0x3 c2 dwe", 32'(c2_dwe), 32'b0111);
      check("SW 0x3 c2 dwdata", c2_dwdata, 32'h00DEADBE);
      check("SW 0x3 c2 ready", 32'(c2_ready), 32'd0);
      issue(mk("LW 0x4 after SW", 1'b0, 3'b010, 32'h4, 32'h0, 32'h88DEADBE, 1'b0, 1));
      issue(mk("LW 0x0 after SW", 1'b0, 3'b010, 32'h0, 32'h0, 32'hEFB62211, 1'b0, 1));

      for (int i = 0; i < 4; i++) issue(errs[i]);
      check("err line0 intact", mem[0], 32'hEFB62211);
      check("err line1 intact", mem[1], 32'h88DEADBE);
      check("err last line intact", mem[4095], 32'hCAFEF00D);

      @(negedge clk);
      n_req_valid = 1'b1; n_req_we = 1'b0; n_req_funct3 = 3'b001; n_req_addr = 32'h3;
      #1;
      check("noMA LH 0x3 dwe", 32'(n_dwe), 32'd0);
      @(posedge clk);
      #1;
      n_req_valid = 1'b0;
      check("noMA LH 0x3 valid", 32'(n_resp_valid), 32'd1);
      check("noMA LH 0x3 err", 32'(n_resp_err), 32'd1);
      @(negedge clk);
      n_req_valid = 1'b1; n_req_we = 1'b1; n_req_funct3 = 3'b010; n_req_addr = 32'h1; n_req_wdata = 32'hFFFFFFFF;
      #1;
      check("noMA SW 0x1 dwe", 32'(n_dwe), 32'd0);
      @(posedge clk);
      #1;
      n_req_valid = 1'b0;
      check("noMA SW 0x1 err", 32'(n_resp_err), 32'd1);
      @(negedge clk);
      n_req_valid = 1'b1; n_req_we = 1'b0; n_req_funct3 = 3'b001; n_req_addr = 32'h2;
      @(posedge clk);
      #1;
      n_req_valid = 1'b0;
      check("noMA LH 0x2 valid", 32'(n_resp_valid), 32'd1);
      check("noMA LH 0x2 err", 32'(n_resp_err), 32'd0);
      check("noMA LH 0x2 rdata", n_resp_rdata, 32'h00001122);

      // Abort a split store in its second cycle.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h3; req_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      #1;
      check("abort pre dwe", 32'(dwe), 32'b0111);
      reset = 1'b1;
      #1;
      check("abort dwe", 32'(dwe), 32'd0);
      check("abort req_ready", 32'(req_ready), 32'd0);
      begin
         int w0;
         int seen;
         w0 = wr_cnt;
         seen = 0;
         @(negedge clk);
         reset = 1'b0;
         for (int k = 0; k < 4; k++) begin
            #1;
            if (resp_valid) seen++;
            @(negedge clk);
         end
         check("abort resp_valid count", 32'(seen), 32'd0);
         check("abort writes", 32'(wr_cnt - w0), 32'd0);
      end
      check("abort req_ready after", 32'(req_ready), 32'd1);
      check("abort line1 intact", mem[1], 32'h88DEADBE);
      check("abort line0 first write", mem[0], 32'h78B62211);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
      $finish;
   end

endmodule
